// File: rtl/reg_file_32x32.sv
// 32-entry register file, one-hot selects, registered reads.
// Ports: clk, rst_n, en, we, rd_sel, wdata, rs1_sel, rs2_sel -> rs1_data, rs2_data, sel_err, wr_count.
module reg_file_32x32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [31:0]       rd_sel,
  input  logic [DATA_W-1:0] wdata,
  input  logic [31:0]       rs1_sel,
  input  logic [31:0]       rs2_sel,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              sel_err,
  output logic [7:0]        wr_count
);

  // Entry 0 is hardwired zero, so only 1..31 hold state.
  logic [DATA_W-1:0] mem [1:31];

  logic              rd_ok;
  logic              rs1_ok;
  logic              rs2_ok;
  logic              wr_hit;
  logic              err_now;
  logic [DATA_W-1:0] rs1_nxt;
  logic [DATA_W-1:0] rs2_nxt;

  function automatic logic onehot(
    input logic [31:0] v
  );
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  assign rd_ok  = onehot(rd_sel);
  assign rs1_ok = onehot(rs1_sel);
  assign rs2_ok = onehot(rs2_sel);

  // A legal select of entry 0 is a silent no-op, not an error.
  assign wr_hit  = en && we && rd_ok && !rd_sel[0];
  assign err_now = en && ((we && !rd_ok) ||
                          !rs1_ok || !rs2_ok);

  // One-hot AND-OR mux; bit 0 contributes nothing.
  always_comb begin
    rs1_nxt = '0;
    rs2_nxt = '0;
    for (int i = 1; i < 32; i++) begin
      if (rs1_sel[i]) rs1_nxt = rs1_nxt | mem[i];
      if (rs2_sel[i]) rs2_nxt = rs2_nxt | mem[i];
    end
    if (!rs1_ok)
      rs1_nxt = '0;
    else if (wr_hit && rs1_sel == rd_sel)
      rs1_nxt = wdata;
    if (!rs2_ok)
      rs2_nxt = '0;
    else if (wr_hit && rs2_sel == rd_sel)
      rs2_nxt = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++)
        mem[i] <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      sel_err  <= 1'b0;
      wr_count <= 8'd0;
    end else if (en) begin
      for (int i = 1; i < 32; i++)
        if (wr_hit && rd_sel[i])
          mem[i] <= wdata;
      rs1_data <= rs1_nxt;
      rs2_data <= rs2_nxt;
      if (err_now)
        sel_err <= 1'b1;
      if (wr_hit && wr_count != 8'hff)
        wr_count <= wr_count + 8'd1;
    end
  end

endmodule
